i2c_target_regs: RTL

- I2C target (responder) for the board's `iic_main` bus. It is the other end of the AXI IIC master used by the RISC-V SoC.
- It exposes an 8-bit-pointer register window to fabric logic, so the SoC can reach board-management registers over I2C. Typical targets are QSFP sideband status and Ethernet status.
- It sits beside the top-level IOBUF pair and uses the split `_i`/`_o`/`_t` signals. SDA is driven open-drain. No clock stretching.

---
 rtl/i2c_target_pkg.sv | 20 ++
 rtl/i2c_input_filter.sv | 53 +++++
 rtl/i2c_target_regs.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types and constants for the I2C register target
// Purpose: FSM state encoding and protocol constants used by i2c_target_regs.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

endpackage

// File: rtl/i2c_input_filter.sv
// rtl/i2c_input_filter.sv - 2-flop synchronizer, glitch filter and edge pulses for one I2C line
// Purpose: condition one raw bus line into a stable level plus one-cycle edge pulses.
// Ports:
//   clock, resetn : system clock, asynchronous active-low reset
//   din           : raw line from the IOBUF
//   level         : filtered level (idle/reset value 1)
//   rise, fall    : one-cycle pulses when the filtered level changes
module i2c_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // A new level is accepted only after FILTER_LEN consecutive synchronized
  // samples disagree with the current level; any agreeing sample restarts it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync_q2;
        cnt   <= '0;
        rise  <= sync_q2;
        fall  <= ~sync_q2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing an 8-bit-pointer register window
// Purpose: respond at TARGET_ADDR on iic_main; a write sets the pointer then
// writes sequential registers, a read streams sequential registers.
// Ports:
//   clock, resetn           : system clock, asynchronous active-low reset
//   scl_i, sda_i            : bus inputs from the IOBUF pair
//   sda_o, sda_t            : open-drain data value (always 0) and tristate (1 = release)
//   busy                    : address-matched START until STOP
//   reg_wr_en/addr/data     : one-cycle register write strobe
//   reg_rd_en/addr, reg_rd_data : one-cycle fetch strobe, data valid the next cycle
import i2c_target_pkg::*;

module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FILTER_LEN  = 4,
  parameter int         HOLD_CYCLES = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic       busy,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_en,
  output logic [7:0] reg_rd_addr,
  input  logic [7:0] reg_rd_data
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clock (clock),
    .resetn(resetn),
    .din   (scl_i),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clock (clock),
    .resetn(resetn),
    .din   (sda_i),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_tgt_state_t state, state_nx;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic [7:0]     ptr;
  logic [HW-1:0]  hold_cnt;
  logic           rd_latch;

  logic       start_det, stop_det, bus_evt;
  logic       last_bit, shifting, addr_match;
  logic [7:0] rx_byte;
  logic       wr_fire, rd_fire, drive_low;
  logic [7:0] rd_fetch_addr;

  assign sda_o      = 1'b0;
  assign start_det  = sda_fall & scl_lvl;
  assign stop_det   = sda_rise & scl_lvl;
  assign bus_evt    = start_det | stop_det;
  assign last_bit   = (bit_cnt == 3'd7);
  assign rx_byte    = {shift[6:0], sda_lvl};
  assign shifting   = state inside {ADDR, PTR, WDATA, RDATA};
  assign addr_match = (rx_byte[7:1] == TARGET_ADDR) && (rx_byte[7:1] != I2C_GENERAL_CALL);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // START/STOP outrank a coincident SCL edge, so a partial byte never completes.
  always_comb begin
    state_nx = state;
    if (stop_det) begin
      state_nx = IDLE;
    end else if (start_det) begin
      state_nx = ADDR;
    end else if (scl_rise) begin
      case (state)
        ADDR:      if (last_bit) state_nx = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK:  state_nx = shift[0] ? RDATA : PTR;
        PTR:       if (last_bit) state_nx = PTR_ACK;
        PTR_ACK:   state_nx = WDATA;
        WDATA:     if (last_bit) state_nx = WDATA_ACK;
        WDATA_ACK: state_nx = WDATA;
        RDATA:     if (last_bit) state_nx = RDATA_ACK;
        RDATA_ACK: state_nx = sda_lvl ? IGNORE : RDATA;
        default:   state_nx = state;
      endcase
    end
  end

  // In ADDR_ACK the shift register still holds the address byte, so bit 0 is R/W.
  always_comb begin
    wr_fire       = 1'b0;
    rd_fire       = 1'b0;
    rd_fetch_addr = (state == RDATA_ACK) ? ptr + 8'd1 : ptr;
    if (!bus_evt && scl_rise) begin
      wr_fire = (state == WDATA) && last_bit;
      rd_fire = ((state == ADDR_ACK) && shift[0]) || ((state == RDATA_ACK) && !sda_lvl);
    end
    case (state)
      ADDR_ACK, PTR_ACK, WDATA_ACK: drive_low = 1'b1;
      RDATA:                        drive_low = ~shift[7];
      default:                      drive_low = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_cnt     <= '0;
      shift       <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
      rd_latch    <= 1'b0;
      busy        <= 1'b0;
      sda_t       <= 1'b1;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      rd_latch  <= reg_rd_en;
      if (stop_det) begin
        bit_cnt  <= '0;
        hold_cnt <= '0;
        busy     <= 1'b0;
        sda_t    <= 1'b1;
      end else if (start_det) begin
        bit_cnt  <= '0;
        hold_cnt <= '0;
      end else begin
        if (scl_rise) begin
          if (shifting) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
          end
          if ((state == ADDR) && last_bit && addr_match) busy <= 1'b1;
          if ((state == PTR) && last_bit) ptr <= rx_byte;
          if (wr_fire) begin
            reg_wr_en   <= 1'b1;
            reg_wr_addr <= ptr;
            reg_wr_data <= rx_byte;
            ptr         <= ptr + 8'd1;
          end
          if (state == RDATA_ACK) ptr <= ptr + 8'd1;
          if (rd_fire) begin
            reg_rd_en   <= 1'b1;
            reg_rd_addr <= rd_fetch_addr;
          end
        end
        // SDA only moves once the hold time after SCL fall has elapsed.
        if (scl_fall) begin
          hold_cnt <= HW'(HOLD_CYCLES);
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HW'(1);
          if (hold_cnt == HW'(1)) sda_t <= ~drive_low;
        end
      end
      // Fetched byte arrives one cycle after the strobe; reload for transmit.
      if (rd_latch) shift <= reg_rd_data;
    end
  end

endmodule
